// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic light controller time-of-day logic.
//   MIN_PER_DAY / MOD_W : minute-of-day range and register width
//   peak_win_t          : one peak window {en, start (inclusive), stop (exclusive)}
//   default_win()       : power-up window table (07-09, 12-14, 17-19, rest disabled)
package tlc_pkg;

  localparam int MIN_PER_DAY = 1440;
  localparam int MOD_W       = 11;
  localparam int MAX_WIN     = 8;

  // stop is the exclusive end of the window ("end" is a keyword)
  typedef struct packed {
    logic             en;
    logic [MOD_W-1:0] start;
    logic [MOD_W-1:0] stop;
  } peak_win_t;

  localparam peak_win_t DEF_W0  = '{en: 1'b1, start: 11'd420,  stop: 11'd540};
  localparam peak_win_t DEF_W1  = '{en: 1'b1, start: 11'd720,  stop: 11'd840};
  localparam peak_win_t DEF_W2  = '{en: 1'b1, start: 11'd1020, stop: 11'd1140};
  localparam peak_win_t WIN_OFF = '{en: 1'b0, start: 11'd0,    stop: 11'd0};

  function automatic peak_win_t default_win(input int idx);
    case (idx)
      0:       return DEF_W0;
      1:       return DEF_W1;
      2:       return DEF_W2;
      default: return WIN_OFF;
    endcase
  endfunction

endpackage

// File: rtl/peak_window_match.sv
// Combinational membership test of one minute-of-day against one peak window.
//   mod   : current minute-of-day 0..1439
//   win   : window {en, start, stop}
//   match : 1 when mod lies inside an enabled, non-empty window
module peak_window_match
  import tlc_pkg::*;
(
  input  logic [MOD_W-1:0] mod,
  input  peak_win_t        win,
  output logic             match
);

  always_comb begin
    match = 1'b0;
    if (win.en && (win.start != win.stop)) begin
      if (win.start < win.stop)
        match = (mod >= win.start) && (mod < win.stop);
      else
        // window wraps through midnight
        match = (mod >= win.start) || (mod < win.stop);
    end
  end

endmodule

// File: rtl/peak_window_scheduler.sv
// Time-of-day keeper and programmable peak-hour classifier for the TLC.
//   clk, rst             : clock, asynchronous active-high reset
//   sec_tick             : one pulse per second
//   time_load, load_hh/mm: load a new time (ignored if out of range)
//   cfg_*                : window write handshake (valid/ready), cfg_err flags a rejected write
//   hh, mm               : current time, 24 h binary
//   peak, peak_win       : registered peak flag and lowest matching window index
//   peak_edge            : one-cycle pulse whenever peak changes
module peak_window_scheduler
  import tlc_pkg::*;
#(
  parameter int N_WIN         = 3,
  parameter int TICKS_PER_MIN = 60,
  parameter int WIDX_W        = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec_tick,
  input  logic              time_load,
  input  logic [4:0]        load_hh,
  input  logic [5:0]        load_mm,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WIDX_W-1:0] cfg_idx,
  input  logic [10:0]       cfg_start,
  input  logic [10:0]       cfg_end,
  input  logic              cfg_en,
  output logic              cfg_err,
  output logic [4:0]        hh,
  output logic [5:0]        mm,
  output logic              peak,
  output logic [WIDX_W-1:0] peak_win,
  output logic              peak_edge
);

  localparam int SEC_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [SEC_W-1:0] SEC_RELOAD = SEC_W'(TICKS_PER_MIN - 1);
  localparam logic [MOD_W-1:0] MOD_LAST   = MOD_W'(MIN_PER_DAY - 1);

  // seconds remaining in the current minute; the minute advances on the tick seen at zero
  logic [SEC_W-1:0]  sec_left;
  logic [MOD_W-1:0]  mod;
  peak_win_t         win_tbl [N_WIN];
  logic [N_WIN-1:0]  match;
  logic              load_ok;
  logic [MOD_W-1:0]  load_mod;
  logic              cfg_accept;
  logic              cfg_bad;
  logic              peak_nxt;
  logic [WIDX_W-1:0] win_nxt;

  assign load_ok    = time_load && (load_hh <= 5'd23) && (load_mm <= 6'd59);
  // hh*60 as hh*64 - hh*4 keeps the load path multiplier-free
  assign load_mod   = MOD_W'({load_hh, 6'b0}) - MOD_W'({load_hh, 2'b0}) + MOD_W'(load_mm);
  assign cfg_accept = cfg_valid && cfg_ready;
  assign cfg_bad    = (32'(cfg_idx) >= N_WIN) || (cfg_start > MOD_LAST) || (cfg_end > MOD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_left <= SEC_RELOAD;
      hh       <= '0;
      mm       <= '0;
      mod      <= '0;
    end else if (load_ok) begin
      sec_left <= SEC_RELOAD;
      hh       <= load_hh;
      mm       <= load_mm;
      mod      <= load_mod;
    end else if (sec_tick) begin
      if (sec_left == '0) begin
        sec_left <= SEC_RELOAD;
        mod      <= (mod == MOD_LAST) ? '0 : mod + 1'b1;
        if (mm == 6'd59) begin
          mm <= '0;
          hh <= (hh == 5'd23) ? '0 : hh + 1'b1;
        end else begin
          mm <= mm + 1'b1;
        end
      end else begin
        sec_left <= sec_left - 1'b1;
      end
    end
  end

  // ready drops for the single cycle following each accepted write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      for (int i = 0; i < N_WIN; i++) win_tbl[i] <= default_win(i);
    end else begin
      cfg_ready <= !cfg_accept;
      cfg_err   <= cfg_accept && cfg_bad;
      if (cfg_accept && !cfg_bad)
        win_tbl[cfg_idx] <= '{en: cfg_en, start: cfg_start, stop: cfg_end};
    end
  end

  for (genvar g = 0; g < N_WIN; g++) begin : g_match
    peak_window_match u_match (
      .mod   (mod),
      .win   (win_tbl[g]),
      .match (match[g])
    );
  end

  always_comb begin
    peak_nxt = |match;
    win_nxt  = '0;
    for (int i = N_WIN - 1; i >= 0; i--) begin
      if (match[i]) win_nxt = WIDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak      <= 1'b0;
      peak_win  <= '0;
      peak_edge <= 1'b0;
    end else begin
      peak      <= peak_nxt;
      peak_win  <= win_nxt;
      peak_edge <= peak_nxt ^ peak;
    end
  end

endmodule
